// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared types and helpers for the programmable sequence detector.
//   state_t  : detector FSM states (UNCFG, ACTIVE)
//   len_mask : 32-bit mask with the low 'len' bits set (len >= 32 -> all ones)
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic {
        UNCFG  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int MASK_W = 32;

    // Always 32 bits wide so callers can compare zero-extended operands of
    // any legal MAX_LEN without leaving unused mask bits behind.
    function automatic logic [MASK_W-1:0] len_mask(input logic [MASK_W-1:0] len);
        if (len >= MASK_W) begin
            return '1;
        end
        return (MASK_W'(1) << len) - MASK_W'(1);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// -----------------------------------------------------------------------------
// seq_det_sat_cnt
// Saturating up-counter; clear has priority over increment.
//   i_clk  : rising-edge clock
//   i_rst  : synchronous active-high reset
//   i_clr  : clear to zero (wins over i_inc)
//   i_inc  : increment by one, holding at all-ones
//   o_cnt  : current count
// -----------------------------------------------------------------------------
module seq_det_sat_cnt #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_det_prog.sv
// -----------------------------------------------------------------------------
// seq_det_prog
// Runtime-programmable serial pattern detector (1..MAX_LEN bit patterns).
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   in         : serial data bit, sampled when in_valid=1
//   in_valid   : data qualifier; idle cycles leave history untouched
//   cfg_load   : latches pattern/pat_len/overlap_en (wins over in_valid)
//   pattern    : pattern[pat_len-1] is the first bit received, pattern[0] last
//   pat_len    : pattern length, legal 1..MAX_LEN
//   overlap_en : 1 = overlapping matches, 0 = restart after each match
//   cnt_clr    : clears match_cnt (wins over a simultaneous match)
//   out        : registered one-cycle match pulse
//   match_cnt  : saturating match count
//   cfg_err    : sticky flag, set by an illegal load, cleared by a legal one
//   active     : high while a legal configuration is loaded (state == ACTIVE)
// Handshake: a bit is consumed on a rising edge where state is ACTIVE,
// in_valid=1 and cfg_load=0; there is no backpressure.
// -----------------------------------------------------------------------------
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap_en,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err,
    output logic               active
);

    if (MAX_LEN < 2 || MAX_LEN > 32) begin : g_bad_max_len
        $error("seq_det_prog: MAX_LEN must be within 2..32");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [MAX_LEN-1:0]   r_hist;
    logic [MAX_LEN-1:0]   r_pat;
    logic [LEN_W-1:0]     r_fill;
    logic [LEN_W-1:0]     r_len;
    logic                 r_ovl;
    logic                 r_out;
    logic                 r_cfg_err;

    logic                 w_cfg_legal;
    logic                 w_shift;
    logic [MAX_LEN-1:0]   w_hist_nxt;
    logic [LEN_W-1:0]     w_fill_nxt;
    logic [MASK_W-1:0]    w_diff;
    logic                 w_match;
    logic                 w_cnt_clr;

    assign w_cfg_legal = cfg_load && (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
    assign w_shift     = (r_state == ACTIVE) && in_valid && !cfg_load;
    assign w_hist_nxt  = {r_hist[MAX_LEN-2:0], in};
    // fill counts bits since the last load/restart, saturating at len_r.
    assign w_fill_nxt  = (r_fill >= r_len) ? r_len : r_fill + LEN_W'(1);
    // Compare only the low len_r bits of the post-shift history.
    assign w_diff      = (MASK_W'(w_hist_nxt) ^ MASK_W'(r_pat)) & len_mask(MASK_W'(r_len));
    assign w_match     = w_shift && (w_diff == '0) && (w_fill_nxt == r_len);

    // FSM next state: only cfg_load moves the detector between states.
    always_comb begin
        w_state_nxt = r_state;
        if (cfg_load) begin
            w_state_nxt = w_cfg_legal ? ACTIVE : UNCFG;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UNCFG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist    <= '0;
            r_pat     <= '0;
            r_fill    <= '0;
            r_len     <= '0;
            r_ovl     <= 1'b0;
            r_out     <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_out <= w_match;
            if (cfg_load) begin
                if (w_cfg_legal) begin
                    r_pat     <= pattern;
                    r_len     <= pat_len;
                    r_ovl     <= overlap_en;
                    r_hist    <= '0;
                    r_fill    <= '0;
                    r_cfg_err <= 1'b0;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end else if (w_shift) begin
                r_hist <= w_hist_nxt;
                // Non-overlapping mode demands len_r fresh bits after a match.
                r_fill <= (w_match && !r_ovl) ? '0 : w_fill_nxt;
            end
        end
    end

    assign w_cnt_clr = cnt_clr || w_cfg_legal;

    seq_det_sat_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_match),
        .o_cnt (match_cnt)
    );

    assign out     = r_out;
    assign cfg_err = r_cfg_err;
    assign active  = (r_state == ACTIVE);

endmodule

// File: tb/tb_seq_det_prog.sv
module tb_seq_det_prog;

    localparam int W = 21;  // {out, cnt16, cnt2, cfg_err, active}

    logic        clk = 1'b0;
    logic        tb_rst = 1'b1;
    logic        tb_in = 1'b0;
    logic        tb_in_valid = 1'b0;
    logic        tb_cfg_load = 1'b0;
    logic [7:0]  tb_pattern = 8'd0;
    logic [3:0]  tb_pat_len = 4'd0;
    logic        tb_overlap_en = 1'b0;
    logic        tb_cnt_clr = 1'b0;

    logic        out_a;
    logic [15:0] cnt_a;
    logic        err_a;
    logic        active_a;
    logic        out_b;
    logic [1:0]  cnt_b;
    logic        err_b;
    logic        active_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    // Reference model state
    bit   m_bits[$];
    int   m_len;
    logic [7:0] m_pat;
    bit   m_ovl;
    bit   m_active;
    bit   m_err;
    int   m_cnt;
    int   m_cnt2;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    seq_det_prog #(.MAX_LEN(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (tb_rst),
        .in         (tb_in),
        .in_valid   (tb_in_valid),
        .cfg_load   (tb_cfg_load),
        .pattern    (tb_pattern),
        .pat_len    (tb_pat_len),
        .overlap_en (tb_overlap_en),
        .cnt_clr    (tb_cnt_clr),
        .out        (out_a),
        .match_cnt  (cnt_a),
        .cfg_err    (err_a),
        .active     (active_a)
    );

    seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) dut_c2 (
        .clk        (clk),
        .rst        (tb_rst),
        .in         (tb_in),
        .in_valid   (tb_in_valid),
        .cfg_load   (tb_cfg_load),
        .pattern    (tb_pattern),
        .pat_len    (tb_pat_len),
        .overlap_en (tb_overlap_en),
        .cnt_clr    (tb_cnt_clr),
        .out        (out_b),
        .match_cnt  (cnt_b),
        .cfg_err    (err_b),
        .active     (active_b)
    );

    // ---------------- driver ----------------
    // Drives one cycle of stimulus, advances the reference model and pushes
    // the expected post-edge outputs. Returns 1 time unit after the edge.
    task automatic drive(input logic b, input logic v, input logic ld, input logic clr,
                         input logic r, input logic [7:0] pat, input logic [3:0] len,
                         input logic ovl);
        bit match;
        bit ld_legal;
        @(negedge clk);
        tb_in = b; tb_in_valid = v; tb_cfg_load = ld; tb_cnt_clr = clr; tb_rst = r;
        tb_pattern = pat; tb_pat_len = len; tb_overlap_en = ovl;
        match = 1'b0;
        ld_legal = 1'b0;
        if (r) begin
            m_active = 1'b0; m_err = 1'b0; m_cnt = 0; m_cnt2 = 0;
            m_bits.delete(); m_len = 0; m_pat = 8'd0; m_ovl = 1'b0;
        end else begin
            if (ld) begin
                if (len >= 4'd1 && len <= 4'd8) begin
                    ld_legal = 1'b1;
                    m_active = 1'b1; m_err = 1'b0;
                    m_pat = pat; m_len = int'(len); m_ovl = ovl;
                    m_bits.delete();
                end else begin
                    m_active = 1'b0; m_err = 1'b1;
                end
            end else if (m_active && v) begin
                m_bits.push_back(b);
                if (m_bits.size() > m_len) void'(m_bits.pop_front());
                if (m_bits.size() == m_len) begin
                    match = 1'b1;
                    // m_bits[0] is the oldest bit and must equal pattern[len-1]
                    for (int i = 0; i < m_len; i++) begin
                        if (m_bits[i] != m_pat[m_len-1-i]) match = 1'b0;
                    end
                    if (match && !m_ovl) m_bits.delete();
                end
            end
            if (clr || ld_legal) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (match) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        exp_q.push_back({match, 16'(m_cnt), 2'(m_cnt2), m_err, m_active});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
    endtask

    task automatic send(input logic b);
        drive(b, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pat, len, ovl);
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {out_a, cnt_a, cnt_b, err_a, active_a};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: actual out=%b cnt=%0d cnt2=%0d err=%b active=%b, expected out=%b cnt=%0d cnt2=%0d err=%b active=%b",
                         $time, act_v[20], act_v[19:4], act_v[3:2], act_v[1], act_v[0],
                         exp_v[20], exp_v[19:4], exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 1'b0);
        n_checks++;
        if ({out_a, cnt_a, err_a, active_a} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state: actual out=%b cnt=%0d err=%b active=%b, expected all 0",
                     out_a, cnt_a, err_a, active_a);
        end
    endtask

    task automatic test_pattern(input string name, input logic [7:0] pat, input logic [3:0] len,
                                input logic ovl, input logic [7:0] stream, input int n,
                                input logic [7:0] exp_pulses, input logic [15:0] exp_cnt);
        logic [7:0] pulses;
        pulses = 8'd0;
        load(pat, len, ovl);
        for (int i = n - 1; i >= 0; i--) begin
            send(stream[i]);
            pulses = {pulses[6:0], out_a};
        end
        n_checks++;
        if (pulses !== exp_pulses) begin
            n_fail++;
            $display("FAIL %s pulses: actual %b, expected %b", name, pulses, exp_pulses);
        end
        n_checks++;
        if (cnt_a !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s match_cnt: actual %0d, expected %0d", name, cnt_a, exp_cnt);
        end
    endtask

    task automatic test_bubbles();
        int np;
        logic [2:0] bits;
        np = 0;
        bits = 3'b101;
        load(8'b101, 4'd3, 1'b1);
        for (int i = 2; i >= 0; i--) begin
            send(bits[i]);
            if (i == 0) begin
                n_checks++;
                if (out_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bubbles_pulse_latency: actual out=%b, expected 1", out_a);
                end
            end
            np += int'(out_a);
            repeat (3) begin
                idle();
                np += int'(out_a);
            end
        end
        n_checks++;
        if (np != 1) begin
            n_fail++;
            $display("FAIL bubbles_pulse_count: actual %0d, expected 1", np);
        end
    endtask

    task automatic test_saturation();
        int exp2[5] = '{1, 2, 3, 3, 3};
        load(8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(1'b1);
            n_checks++;
            if (int'(cnt_b) != exp2[i] || int'(cnt_a) != i + 1) begin
                n_fail++;
                $display("FAIL saturation_step%0d: actual cnt2=%0d cnt16=%0d, expected cnt2=%0d cnt16=%0d",
                         i, cnt_b, cnt_a, exp2[i], i + 1);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0, 1'b0);
        n_checks++;
        if (cnt_a !== 16'd0 || cnt_b !== 2'd0 || out_a !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_match: actual cnt16=%0d cnt2=%0d out=%b, expected 0 0 1",
                     cnt_a, cnt_b, out_a);
        end
    endtask

    task automatic test_illegal_cfg();
        int np;
        logic [5:0] s;
        np = 0;
        s = 6'b101101;
        load(8'b101, 4'd0, 1'b1);
        n_checks++;
        if (err_a !== 1'b1 || active_a !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_cfg: actual err=%b active=%b, expected 1 0", err_a, active_a);
        end
        for (int i = 5; i >= 0; i--) begin
            send(s[i]);
            np += int'(out_a);
        end
        n_checks++;
        if (np != 0) begin
            n_fail++;
            $display("FAIL uncfg_pulses: actual %0d, expected 0", np);
        end
        load(8'h05, 4'd9, 1'b1);
        n_checks++;
        if (err_a !== 1'b1 || active_a !== 1'b0) begin
            n_fail++;
            $display("FAIL len9_cfg: actual err=%b active=%b, expected 1 0", err_a, active_a);
        end
        load(8'b101, 4'd3, 1'b1);
        n_checks++;
        if (err_a !== 1'b0 || active_a !== 1'b1) begin
            n_fail++;
            $display("FAIL legal_after_err: actual err=%b active=%b, expected 0 1", err_a, active_a);
        end
        send(1'b1);
        send(1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 1'b0);
        send(1'b1);
        n_checks++;
        if (out_a !== 1'b0 || active_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midstream: actual out=%b active=%b, expected 0 0", out_a, active_a);
        end
    endtask

    task automatic test_back_to_back();
        load(8'($urandom_range(0, 255)), 4'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 1'b0);
                load(8'($urandom_range(0, 255)), 4'($urandom_range(1, 3)), 1'b1);
            end else if ($urandom_range(0, 99) < 5) begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                      1'($urandom_range(0, 99) < 20), 1'b0, 8'($urandom_range(0, 255)),
                      4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
            end else begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0,
                      1'($urandom_range(0, 99) < 3), 1'b0, 8'd0, 4'd0, 1'b0);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_pattern("ovl_101",   8'b101,  4'd3, 1'b1, 8'b10101,   5, 8'b00101,   16'd2);
        test_pattern("novl_101",  8'b101,  4'd3, 1'b0, 8'b10101,   5, 8'b00100,   16'd1);
        test_pattern("ovl_1101",  8'b1101, 4'd4, 1'b1, 8'b1101101, 7, 8'b0001001, 16'd2);
        test_pattern("novl_1101", 8'b1101, 4'd4, 1'b0, 8'b1101101, 7, 8'b0001000, 16'd1);
        test_pattern("len8",      8'hA5,   4'd8, 1'b1, 8'hA5,      8, 8'b00000001, 16'd1);
        test_bubbles();
        test_saturation();
        test_illegal_cfg();
        test_back_to_back();
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
Runtime-programmable serial pattern detector, the parametrised successor of the fixed 3-bit detectors in the sequence-detector library.
- Detects any pattern of 1..MAX_LEN bits, loaded at runtime, in a 1-bit stream qualified by a valid strobe.
- Supports overlapping and non-overlapping modes.
- Counts matches in a saturating counter and flags illegal configurations.
- Sits directly on a serial data path; match pulses feed downstream framing/alignment logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (legal range 2..32).
LEN_W, $clog2(MAX_LEN+1), width of pattern-length fields.
CNT_W, 16, width of the match counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in  input  1  serial data bit.
in_valid  input  1  in is sampled only when 1.
cfg_load  input  1  one-cycle strobe that latches pattern, pat_len and overlap_en.
pattern  input  MAX_LEN  pattern; pattern[pat_len-1] is the first bit received, pattern[0] the last.
pat_len  input  LEN_W  pattern length, legal range 1..MAX_LEN.
overlap_en  input  1  1 = overlapping, 0 = non-overlapping.
cnt_clr  input  1  clears match_cnt.
out  output  1  registered one-cycle match pulse.
match_cnt  output  CNT_W  saturating match count.
cfg_err  output  1  sticky illegal-configuration flag.
active  output  1  1 while a legal configuration is loaded.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = UNCFG; out=0, match_cnt=0, cfg_err=0, active=0.
  - hist, fill, pat_r, len_r, ovl_r all cleared.
  - Reset mid-stream discards all partial history.
- States:
  - UNCFG: in ignored, out=0.
  - ACTIVE: detection running. active = (state==ACTIVE).
- cfg_load handling:
  - Legal pat_len (1..MAX_LEN): latch pat_r/len_r/ovl_r; clear hist, fill and match_cnt; cfg_err=0; go to ACTIVE.
  - Illegal pat_len (0 or >MAX_LEN): cfg_err=1, go to UNCFG, registers untouched otherwise.
  - cfg_load has priority over in_valid in the same cycle; that bit is discarded.
- Shifting (ACTIVE, in_valid=1, no cfg_load):
  - hist <= {hist[MAX_LEN-2:0], in}.
  - fill <= min(fill+1, len_r), saturating.
  - in_valid=0 leaves hist and fill unchanged; bubbles are transparent.
- Match condition, evaluated on the shifted-in value:
  - The low len_r bits of the new hist equal the low len_r bits of pat_r (masked compare).
  - The new fill equals len_r, i.e. at least len_r bits received since the last cfg_load or match restart.
- On match:
  - out=1 in the cycle after the edge that sampled the completing bit; latency is 1 clk and the pulse lasts exactly one cycle.
  - ovl_r=1: fill is kept, so a shared suffix/prefix can produce a match on the very next valid bit.
  - ovl_r=0: fill <= 0, so the next match needs len_r fresh bits. hist is still shifted.
- match_cnt:
  - Increments on each match and saturates at 2^CNT_W-1; no wrap.
  - cnt_clr with a simultaneous match: clear wins, result 0.
- Out-of-range MAX_LEN is rejected by an elaboration-time check.

Decomposition:
- Package seq_det_pkg: state enum (UNCFG, ACTIVE) and a function computing the pattern mask from a length.
- One sub-module, seq_det_sat_cnt: a parametrised saturating counter with clear and increment inputs, priority clear > inc.

Test Plan:
- MAX_LEN=8, cfg pattern=3'b101, pat_len=3, overlap_en=1, stream 1,0,1,0,1 (in_valid=1) -> out pulses after bits 3 and 5; match_cnt=2.
- Same stream with overlap_en=0 -> single pulse after bit 3; match_cnt=1.
- pattern=4'b1101, pat_len=4, stream 1,1,0,1,1,0,1 -> overlap: pulses after bits 4 and 7; non-overlap: after bit 4 only.
- pattern=101 with in_valid deasserted for 3 cycles between each bit -> still exactly one pulse, 1 cycle after the final valid bit.
- CNT_W=2, overlap pattern=1, pat_len=1, five 1s -> match_cnt 1,2,3,3,3; cnt_clr asserted together with a match -> match_cnt=0.
- cfg_load with pat_len=0 -> cfg_err=1, active=0, no pulses for any stream. A following legal load -> cfg_err=0, active=1. rst asserted mid-pattern (after "10") then "1" -> no pulse, active=0.
